// File: rtl/pc_src_ctrl.sv
// PC-source / memory-address mux sequencer for the multicycle CPU.
// Optional completed-exception counter enabled by defining EXC_COUNT_EN.
module pc_src_ctrl #(
   parameter int unsigned MEM_LAT = 1,
   parameter int unsigned COUNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               op_req,
   input  logic [1:0]         op_kind,
   input  logic               branch_taken,
   input  logic               exc_req,
   input  logic [1:0]         exc_code,
   output logic [2:0]         pc_src,
   output logic               pc_write,
   output logic               epc_write,
   output logic [2:0]         mem_addr_src,
   output logic [1:0]         vec_sel,
   output logic               mem_read,
   output logic               op_ack,
   output logic               exc_ack,
   output logic               busy,
   output logic [COUNT_W-1:0] exc_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEQ,
      S_BRANCH,
      S_JUMP,
      S_RET,
      S_EXC_SAVE,
      S_EXC_READ,
      S_EXC_LOAD
   } state_t;

   localparam logic [2:0] PC_ALU    = 3'd0;
   localparam logic [2:0] PC_ALUOUT = 3'd1;
   localparam logic [2:0] PC_JUMP   = 3'd2;
   localparam logic [2:0] PC_VEC    = 3'd3;
   localparam logic [2:0] PC_EPC    = 3'd4;
   localparam logic [2:0] ADDR_PC   = 3'd0;
   localparam logic [2:0] ADDR_VEC  = 3'd4;

   localparam int unsigned LAT_W   = 4;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

   state_t           state;
   state_t           state_nx;
   logic [LAT_W-1:0] lat_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Vector index is captured at arbitration so later exc_code changes are ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         vec_sel <= 2'd0;
         lat_cnt <= '0;
      end else begin
         if (state == S_IDLE && exc_req) begin
            vec_sel <= (exc_code == 2'd3) ? 2'd0 : exc_code;
         end
         if (state == S_EXC_SAVE) begin
            lat_cnt <= LAT_LOAD;
         end else if (state == S_EXC_READ && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
         end
      end
   end

   // NOTE: every combinational output gets a default before the case so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (exc_req) begin
               state_nx = S_EXC_SAVE;
            end else if (op_req) begin
               case (op_kind)
                  2'd0:    state_nx = S_SEQ;
                  2'd1:    state_nx = S_BRANCH;
                  2'd2:    state_nx = S_JUMP;
                  default: state_nx = S_RET;
               endcase
            end
         end
         S_SEQ, S_BRANCH, S_JUMP, S_RET: state_nx = S_IDLE;
         S_EXC_SAVE: state_nx = S_EXC_READ;
         S_EXC_READ: begin
            if (lat_cnt == '0) begin
               state_nx = S_EXC_LOAD;
            end
         end
         S_EXC_LOAD: state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   // Moore decode; branch_taken is the sole input reaching an output.
   always_comb begin
      pc_src       = PC_ALU;
      pc_write     = 1'b0;
      epc_write    = 1'b0;
      mem_addr_src = ADDR_PC;
      mem_read     = 1'b0;
      op_ack       = 1'b0;
      exc_ack      = 1'b0;
      busy         = (state != S_IDLE);
      case (state)
         S_SEQ: begin
            pc_src   = PC_ALU;
            pc_write = 1'b1;
            op_ack   = 1'b1;
         end
         S_BRANCH: begin
            pc_src   = PC_ALUOUT;
            pc_write = branch_taken;
            op_ack   = 1'b1;
         end
         S_JUMP: begin
            pc_src   = PC_JUMP;
            pc_write = 1'b1;
            op_ack   = 1'b1;
         end
         S_RET: begin
            pc_src   = PC_EPC;
            pc_write = 1'b1;
            op_ack   = 1'b1;
         end
         S_EXC_SAVE: begin
            epc_write = 1'b1;
         end
         S_EXC_READ: begin
            mem_addr_src = ADDR_VEC;
            mem_read     = 1'b1;
         end
         S_EXC_LOAD: begin
            mem_addr_src = ADDR_VEC;
            pc_src       = PC_VEC;
            pc_write     = 1'b1;
            exc_ack      = 1'b1;
         end
         default: begin
         end
      endcase
   end

`ifdef EXC_COUNT_EN
   logic [COUNT_W-1:0] exc_cnt_q;

   // Saturating: holds at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         exc_cnt_q <= '0;
      end else if (exc_ack && exc_cnt_q != '1) begin
         exc_cnt_q <= exc_cnt_q + COUNT_W'(1);
      end
   end

   assign exc_count = exc_cnt_q;
`else
   assign exc_count = '0;
`endif

endmodule

// File: tb/tb_pc_src_ctrl.sv
// Randomized bench for pc_src_ctrl: a transaction-level model expands each
// accepted request into its expected per-cycle output schedule.
module tb_pc_src_ctrl;

   localparam int unsigned MEM_LAT = 3;
   localparam int unsigned COUNT_W = 2;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               op_req = 1'b0;
   logic [1:0]         op_kind = 2'd0;
   logic               branch_taken = 1'b0;
   logic               exc_req = 1'b0;
   logic [1:0]         exc_code = 2'd0;
   logic [2:0]         pc_src;
   logic               pc_write;
   logic               epc_write;
   logic [2:0]         mem_addr_src;
   logic [1:0]         vec_sel;
   logic               mem_read;
   logic               op_ack;
   logic               exc_ack;
   logic               busy;
   logic [COUNT_W-1:0] exc_count;

   pc_src_ctrl #(.MEM_LAT(MEM_LAT), .COUNT_W(COUNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .op_req       (op_req),
      .op_kind      (op_kind),
      .branch_taken (branch_taken),
      .exc_req      (exc_req),
      .exc_code     (exc_code),
      .pc_src       (pc_src),
      .pc_write     (pc_write),
      .epc_write    (epc_write),
      .mem_addr_src (mem_addr_src),
      .vec_sel      (vec_sel),
      .mem_read     (mem_read),
      .op_ack       (op_ack),
      .exc_ack      (exc_ack),
      .busy         (busy),
      .exc_count    (exc_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] pc_src;
      logic       pc_write;
      logic       epc_write;
      logic [2:0] mem_addr_src;
      logic       mem_read;
      logic       op_ack;
      logic       exc_ack;
      logic       busy;
   } obs_t;

   obs_t        exp_q[$];
   logic [1:0]  m_vec;
   int unsigned m_cnt;
   int          total = 0;
   int          bad = 0;
   int unsigned p_exc = 0;
   int unsigned p_op = 0;
   bit          force_exc = 0;
   bit          force_op = 0;
   logic [1:0]  force_kind = 2'd0;
   int unsigned n_exc = 0;
   int unsigned n_ops = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic obs_t sample_obs();
      obs_t o;
      o.pc_src       = pc_src;
      o.pc_write     = pc_write;
      o.epc_write    = epc_write;
      o.mem_addr_src = mem_addr_src;
      o.mem_read     = mem_read;
      o.op_ack       = op_ack;
      o.exc_ack      = exc_ack;
      o.busy         = busy;
      return o;
   endfunction

   function automatic logic [31:0] exp_count();
`ifdef EXC_COUNT_EN
      return 32'(m_cnt);
`else
      return 32'd0;
`endif
   endfunction

   // One-cycle op: mux select from the op table, always acked.
   function automatic obs_t op_obs(input logic [1:0] kind, input logic bt);
      obs_t o = '0;
      o.busy   = 1'b1;
      o.op_ack = 1'b1;
      case (kind)
         2'd0:    begin o.pc_src = 3'd0; o.pc_write = 1'b1; end
         2'd1:    begin o.pc_src = 3'd1; o.pc_write = bt;   end
         2'd2:    begin o.pc_src = 3'd2; o.pc_write = 1'b1; end
         default: begin o.pc_src = 3'd4; o.pc_write = 1'b1; end
      endcase
      return o;
   endfunction

   task automatic push_exc();
      obs_t o;
      o = '0; o.busy = 1'b1; o.epc_write = 1'b1;
      exp_q.push_back(o);
      for (int i = 0; i < int'(MEM_LAT); i++) begin
         o = '0; o.busy = 1'b1; o.mem_addr_src = 3'd4; o.mem_read = 1'b1;
         exp_q.push_back(o);
      end
      o = '0; o.busy = 1'b1; o.mem_addr_src = 3'd4; o.pc_src = 3'd3;
      o.pc_write = 1'b1; o.exc_ack = 1'b1;
      exp_q.push_back(o);
   endtask

   // Compare this cycle at the falling edge, then set inputs for the next rising edge.
   task automatic step();
      obs_t exp;
      bit   was_idle;
      @(negedge clk);
      was_idle = (exp_q.size() == 0);
      exp = was_idle ? obs_t'('0) : exp_q.pop_front();
      check("outputs", 32'(sample_obs()), 32'(exp));
      check("vec_sel", 32'(vec_sel), 32'(m_vec));
      check("exc_count", 32'(exc_count), exp_count());
      if (exp.epc_write && exp.pc_write) check("epc_pc_overlap", 32'(epc_write & pc_write), 32'd0);
      if (exp.op_ack) op_req = 1'b0;
      if (exp.exc_ack) begin
         exc_req = 1'b0;
         if (m_cnt < (1 << COUNT_W) - 1) m_cnt++;
      end
      branch_taken = 1'($urandom_range(0, 1));
      exc_code     = 2'($urandom);
      if (!op_req) op_kind = 2'($urandom);
      if (!exc_req && !exp.exc_ack && (force_exc || $urandom_range(0, 99) < p_exc)) exc_req = 1'b1;
      if (!op_req && !exp.op_ack && (force_op || $urandom_range(0, 99) < p_op)) begin
         op_req = 1'b1;
         if (force_op) op_kind = force_kind;
      end
      force_exc = 0;
      force_op  = 0;
      if (was_idle) begin
         if (exc_req) begin
            m_vec = (exc_code == 2'd3) ? 2'd0 : exc_code;
            push_exc();
            n_exc++;
         end else if (op_req) begin
            exp_q.push_back(op_obs(op_kind, branch_taken));
            n_ops++;
         end
      end
   endtask

   // Reset is raised right after a falling edge and held for two rising edges.
   task automatic do_reset();
      reset   = 1'b1;
      exc_req = 1'b0;
      op_req  = 1'b0;
      exp_q.delete();
      m_vec = 2'd0;
      m_cnt = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_outputs", 32'(sample_obs()), 32'd0);
         check("rst_vec_sel", 32'(vec_sel), 32'd0);
         check("rst_exc_count", 32'(exc_count), 32'd0);
      end
      reset = 1'b0;
   endtask

   task automatic drain();
      bit done = 0;
      p_exc = 0;
      p_op  = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         step();
         done = (exp_q.size() == 0) && !exc_req && !op_req;
      end
      check("drain_done", 32'(done), 32'd1);
   endtask

   initial begin
      m_vec = 2'd0;
      m_cnt = 0;
      do_reset();
      step();

      // Exception and return-from-exception op raised together.
      force_exc  = 1;
      force_op   = 1;
      force_kind = 2'd3;
      step();
      drain();

      // Back-to-back branches, then a burst of exceptions to reach saturation.
      for (int k = 0; k < 2; k++) begin
         force_op   = 1;
         force_kind = 2'd1;
         step();
         drain();
      end
      for (int k = 0; k < 5; k++) begin
         force_exc = 1;
         step();
         drain();
      end

      p_exc = 15;
      p_op  = 40;
      for (int i = 0; i < 3000; i++) step();
      drain();

      // Reset while the vector read is in flight.
      force_exc = 1;
      step();
      step();
      step();
      check("pre_rst_mem_read", 32'(mem_read), 32'd1);
      do_reset();
      step();

      p_exc = 20;
      p_op  = 30;
      for (int i = 0; i < 500; i++) step();
      drain();

      check("saw_traffic", 32'(n_exc > 20 && n_ops > 50), 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_src_ctrl.md
Name: pc_src_ctrl

Overview:
Sequencer for the multicycle CPU's 5-input PC-source mux and the 5-input memory-address mux.
- Accepts one-cycle PC-update requests from the main control FSM and multi-cycle exception requests from the ALU/decoder.
- Arbitrates between the two request sources; exception requests have priority.
- Drives the mux selects, PC/EPC write enables and the vector-table memory read.

Parameters:
MEM_LAT, 1, memory read latency in cycles from mem_read assertion to valid data; legal range 1..15.
COUNT_W, 8, width of the exception counter (Optional Feature).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
op_req  input  1  PC-update request; level, held until op_ack
op_kind  input  2  0 sequential (PC+4), 1 branch, 2 jump, 3 return-from-exception
branch_taken  input  1  ALU branch condition; sampled only in S_BRANCH
exc_req  input  1  exception request; level, held until exc_ack
exc_code  input  2  0 invalid opcode, 1 overflow, 2 div-by-zero, 3 treated as 0
pc_src  output  3  PC mux select: 0 ALU result, 1 ALUOut, 2 jump target, 3 vector byte, 4 EPC
pc_write  output  1  PC write enable
epc_write  output  1  EPC write enable
mem_addr_src  output  3  address mux select: 0 PC, 4 vector address; other codes never driven
vec_sel  output  2  vector index latched from exc_code
mem_read  output  1  memory read strobe for the vector fetch
op_ack  output  1  one-cycle pulse, op request completed
exc_ack  output  1  one-cycle pulse, exception sequence completed
busy  output  1  1 whenever state != S_IDLE
exc_count  output  COUNT_W  completed-exception count (Optional Feature)

Behaviour:
- States: S_IDLE, S_SEQ, S_BRANCH, S_JUMP, S_RET, S_EXC_SAVE, S_EXC_READ, S_EXC_LOAD.
- Outputs are Moore, decoded from the registered state. The only exception is pc_write in S_BRANCH, which equals branch_taken.
- Reset: state=S_IDLE, latency counter=0, vec_sel=0, exc_count=0. All outputs 0 (pc_src=0, mem_addr_src=0).
- S_IDLE arbitration:
  - exc_req=1 -> S_EXC_SAVE, latch vec_sel<=exc_code (3 maps to 0). This wins even if op_req=1 in the same cycle; the op stays pending.
  - else op_req=1 -> S_SEQ/S_BRANCH/S_JUMP/S_RET per op_kind.
  - else stay in S_IDLE.
- Op states last 1 cycle each:
  - S_SEQ: pc_src=0, pc_write=1.
  - S_BRANCH: pc_src=1, pc_write=branch_taken.
  - S_JUMP: pc_src=2, pc_write=1.
  - S_RET: pc_src=4, pc_write=1.
  - All op states assert op_ack=1 and then go to S_IDLE.
- Exception sequence:
  - S_EXC_SAVE: epc_write=1, 1 cycle; loads counter=MEM_LAT-1, then S_EXC_READ.
  - S_EXC_READ: mem_addr_src=4, mem_read=1. Counter decrements each cycle; leave to S_EXC_LOAD when counter==0, i.e. after exactly MEM_LAT cycles.
  - S_EXC_LOAD: mem_addr_src=4, pc_src=3, pc_write=1, exc_ack=1. Then S_IDLE.
- Latency, with the request first seen in S_IDLE at cycle 0:
  - Op: ack at cycle 1.
  - Exception: ack at cycle 2+MEM_LAT.
  - Minimum request spacing is 2 cycles, because the block always returns to S_IDLE.
- Requests arriving while busy=1 are not sampled. exc_code/op_kind changes during a sequence have no effect because vec_sel is latched.
- Requester must drop the request in the cycle after ack. A request still high in S_IDLE is treated as a new request.
- Reset asserted in any state: next cycle S_IDLE with all outputs 0. An in-flight sequence is abandoned with no ack.
- The controller never asserts epc_write and pc_write in the same cycle.

Optional Feature:
Macro EXC_COUNT_EN.
- Defined: exc_count increments by 1 on each cycle with exc_ack=1. It saturates at 2^COUNT_W-1 (no wrap) and is cleared by reset.
- Undefined: exc_count is tied to 0 and no counter register is synthesized. The port is present in both builds.

Test Plan:
- Reset held 2 cycles in S_EXC_READ with MEM_LAT=3 -> next cycle state S_IDLE, busy=0, mem_read=0, no exc_ack.
- op_req=1, op_kind=0 -> cycle 1: pc_src=0, pc_write=1, op_ack=1; cycle 2: busy=0.
- op_kind=1 issued twice, branch_taken=0 then 1 -> pc_src=1 both times; pc_write=0 then 1; op_ack=1 both times.
- exc_req=1, exc_code=2, MEM_LAT=2 -> epc_write at cycle 1; mem_read/mem_addr_src=4 at cycles 2-3; cycle 4: pc_src=3, pc_write=1, exc_ack=1, vec_sel=2.
- exc_req and op_req (op_kind=3) asserted together -> exception sequence runs first; the op is then served with pc_src=4 and op_ack, 1 cycle after returning to S_IDLE.
- With EXC_COUNT_EN and COUNT_W=2, run 5 exceptions -> exc_count reads 1,2,3,3,3. Without the macro, exc_count stays 0.
